// File: rtl/frac_div_pkg.sv
// frac_div_pkg: shared types and constants for the fractional clock scheduler.
//   state_e : output-period FSM (IDLE, RUN, STOP)
//   calc_e  : divider sub-FSM (C_IDLE, C_BUSY)
//   Q_MIN   : smallest legal integer period (M >= Q_MIN*N)
//   W_DEF   : default config width
package frac_div_pkg;
  localparam int W_DEF = 8;
  localparam int Q_MIN = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_BUSY = 1'b1
  } calc_e;
endpackage

// File: rtl/int_div_seq.sv
// int_div_seq: sequential restoring divider, one quotient bit per cycle.
// Ports:
//   clk_in, rst (async, active-low)
//   start    : load dividend/divisor and begin (ignored while busy)
//   dividend : W-bit numerator, divisor : W-bit denominator (non-zero)
//   done     : 1-cycle pulse, W+1 cycles after start; quo/rem valid from then
//   quo, rem : registered results
module int_div_seq
  import frac_div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem
);
  localparam int CW = $clog2(W) + 1;

  calc_e         state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quo_q, quo_d, rem_q, rem_d, den_q, den_d;
  logic          done_q, done_d;
  logic [W:0]    trial;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    den_d   = den_q;
    done_d  = 1'b0;
    // Shift the next dividend bit into the partial remainder.
    trial   = {rem_q, quo_q[W-1]};
    case (state_q)
      C_IDLE: begin
        if (start) begin
          quo_d   = dividend;
          rem_d   = '0;
          den_d   = divisor;
          cnt_d   = '0;
          state_d = C_BUSY;
        end
      end
      C_BUSY: begin
        if (trial >= {1'b0, den_q}) begin
          rem_d = W'(trial - {1'b0, den_q});
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = trial[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = C_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign quo  = quo_q;
  assign rem  = rem_q;
endmodule

// File: rtl/frac_div_sched.sv
// frac_div_sched: runtime-configurable fractional clock scheduler.
// clk_out has an average period of M/N clk_in cycles, built from periods of
// Q and Q+1 cycles (Q=M/N, R=M%N) spread by an error accumulator.
// Ports:
//   clk_in, rst (async, active-low)
//   cfg_valid/cfg_ready/cfg_m/cfg_n : config handshake (M, N)
//   cfg_err      : 1-cycle pulse when a config is rejected (N=0 or M<2N)
//   en           : enable period generation
//   clk_out      : divided clock (high floor(L/2), low the rest)
//   period_start : pulse on the first high cycle of each period
//   busy         : high while a period is in progress
// Build option: FRAC_DIV_DEFAULT_CFG_EN makes DEF_M/DEF_N the active config
// at reset; otherwise en is ignored until a legal config has been applied.
module frac_div_sched
  import frac_div_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEF_M = 87,
  parameter int DEF_N = 10
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_m,
  input  logic [W-1:0] cfg_n,
  input  logic         en,
  output logic         clk_out,
  output logic         period_start,
  output logic         busy,
  output logic         cfg_err
);
  localparam logic [W-1:0] DEF_Q  = W'(DEF_M / DEF_N);
  localparam logic [W-1:0] DEF_R  = W'(DEF_M % DEF_N);
  localparam logic [W-1:0] DEF_NV = W'(DEF_N);
  // The active-config registers always reset to the defaults; only the
  // valid flag decides whether they count as a usable config.
`ifdef FRAC_DIV_DEFAULT_CFG_EN
  localparam logic DEF_VLD = 1'b1;
`else
  localparam logic DEF_VLD = 1'b0;
`endif

  state_e       state_q, state_d;
  logic         cfg_ready_q, cfg_ready_d, cfg_err_q, cfg_err_d;
  logic         pend_q, pend_d, avld_q, avld_d;
  logic [W-1:0] sq_q, sq_d, sr_q, sr_d, rn_q, rn_d;   // shadow Q/R, requested N
  logic [W-1:0] aq_q, aq_d, ar_q, ar_d, an_q, an_d;   // active Q/R/N
  logic [W-1:0] acc_q, acc_d;
  logic [W:0]   cnt_q, cnt_d, len_q, len_d;           // W+1 bits: Q+1 may be 2^W
  logic         clk_q, clk_d, ps_q, ps_d, busy_q, busy_d;

  logic         accept, legal, div_start, div_done, pend_eff, last, apply, launch, long_p;
  logic [W-1:0] div_q, div_r, nq, nr, q_sel, r_sel, n_sel, acc_base;
  logic [W:0]   acc_sum;

  int_div_seq #(.W(W)) u_div (
    .clk_in   (clk_in),
    .rst      (rst),
    .start    (div_start),
    .dividend (cfg_m),
    .divisor  (cfg_n),
    .done     (div_done),
    .quo      (div_q),
    .rem      (div_r)
  );

  always_comb begin
    accept    = cfg_valid && cfg_ready_q;
    legal     = (cfg_n != '0) &&
                ((W+2)'(cfg_m) >= (W+2)'(Q_MIN) * (W+2)'(cfg_n));
    div_start = accept && legal;

    // A divider result arriving on a boundary cycle is usable right away.
    pend_eff = pend_q || div_done;
    nq       = div_done ? div_q : sq_q;
    nr       = div_done ? div_r : sr_q;
    last     = busy_q && (cnt_q == len_q);
    apply    = pend_eff && (!busy_q || last);
    launch   = (state_q == RUN) && en && (!busy_q || last);

    q_sel    = apply ? nq   : aq_q;
    r_sel    = apply ? nr   : ar_q;
    n_sel    = apply ? rn_q : an_q;
    // Fresh config or a fresh run restarts the error accumulator.
    acc_base = (apply || !busy_q) ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + {1'b0, r_sel};
    long_p   = acc_sum >= {1'b0, n_sel};

    state_d     = state_q;
    cfg_ready_d = cfg_ready_q;
    cfg_err_d   = 1'b0;
    pend_d      = pend_q;
    avld_d      = avld_q;
    sq_d        = sq_q;
    sr_d        = sr_q;
    rn_d        = rn_q;
    aq_d        = aq_q;
    ar_d        = ar_q;
    an_d        = an_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    clk_d       = 1'b0;
    ps_d        = launch;
    busy_d      = busy_q;

    if (accept) begin
      if (legal) begin
        cfg_ready_d = 1'b0;
        rn_d        = cfg_n;
      end else begin
        cfg_err_d   = 1'b1;
      end
    end

    if (div_done) begin
      sq_d   = div_q;
      sr_d   = div_r;
      pend_d = 1'b1;
    end

    if (apply) begin
      aq_d        = nq;
      ar_d        = nr;
      an_d        = rn_q;
      avld_d      = 1'b1;
      pend_d      = 1'b0;
      cfg_ready_d = 1'b1;
      acc_d       = '0;
    end

    if (launch) begin
      len_d  = long_p ? {1'b0, q_sel} + (W+1)'(1) : {1'b0, q_sel};
      acc_d  = long_p ? W'(acc_sum - {1'b0, n_sel}) : acc_sum[W-1:0];
      cnt_d  = (W+1)'(1);
      clk_d  = 1'b1;
      busy_d = 1'b1;
    end else if (last) begin
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (busy_q) begin
      cnt_d  = cnt_q + 1'b1;
      clk_d  = (cnt_q + 1'b1) <= (len_q >> 1);
    end

    case (state_q)
      IDLE:    if (en && avld_q) state_d = RUN;
      RUN:     if (!en) state_d = STOP;
      STOP:    if (!busy_q || last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      pend_q      <= 1'b0;
      avld_q      <= DEF_VLD;
      sq_q        <= '0;
      sr_q        <= '0;
      rn_q        <= '0;
      aq_q        <= DEF_Q;
      ar_q        <= DEF_R;
      an_q        <= DEF_NV;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      clk_q       <= 1'b0;
      ps_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      pend_q      <= pend_d;
      avld_q      <= avld_d;
      sq_q        <= sq_d;
      sr_q        <= sr_d;
      rn_q        <= rn_d;
      aq_q        <= aq_d;
      ar_q        <= ar_d;
      an_q        <= an_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      clk_q       <= clk_d;
      ps_q        <= ps_d;
      busy_q      <= busy_d;
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign cfg_err      = cfg_err_q;
  assign clk_out      = clk_q;
  assign period_start = ps_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_frac_div_sched.sv
// Bench for frac_div_sched (W=8). A negedge monitor measures each output
// period (length and high cycles) and compares it against an expected queue
// filled by the stimulus; config handshake and corner cases are checked inline.
module tb_frac_div_sched;
  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_m = '0;
  logic [7:0] cfg_n = '0;
  logic       en = 1'b0;
  logic       clk_out, period_start, busy, cfg_err;

  frac_div_sched #(.W(8)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_m        (cfg_m),
    .cfg_n        (cfg_n),
    .en           (en),
    .clk_out      (clk_out),
    .period_start (period_start),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int len; int hi; } exp_t;
  typedef struct { int m; int n; bit legal; int nper; } vec_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ps_cnt = 0;
  int   tot_len = 0;
  bit   inp = 1'b0;
  int   pc = 0;
  int   ph = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic fin(input int len, input int hi);
    exp_t e;
    tot_len += len;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL period_unexpected: got len %0d hi %0d expected none", len, hi);
    end else begin
      e = exp_q.pop_front();
      chk("period_len", len, e.len);
      chk("period_hi", hi, e.hi);
    end
  endtask

  // Period monitor: a period runs from its period_start pulse to the next
  // pulse or to the cycle busy falls; reset discards a partial period.
  always @(negedge clk_in) begin
    if (!rst) begin
      inp = 1'b0;
    end else begin
      if (period_start) begin
        ps_cnt++;
        if (inp) fin(pc, ph);
        inp = 1'b1;
        pc  = 0;
        ph  = 0;
      end else if (inp && !busy) begin
        fin(pc, ph);
        inp = 1'b0;
      end
      if (inp) begin
        pc++;
        if (clk_out) ph++;
      end
    end
  end

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic push_model(input int m, input int n, input int k);
    for (int i = 0; i < k; i++) begin
      int l;
      l = ((i + 1) * m) / n - (i * m) / n;
      exp_q.push_back('{l, l / 2});
    end
  endtask

  task automatic wait_ps(input int target, input int budget);
    int c;
    c = 0;
    while (ps_cnt < target && c < budget) begin
      step();
      c++;
    end
    if (ps_cnt < target) chk("ps_timeout", ps_cnt, target);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 600) begin
      step();
      c++;
    end
    chk("idle_busy", busy, 0);
    chk("idle_clk_out", clk_out, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic run_periods(input int k);
    int base;
    en   = 1'b1;
    base = ps_cnt;
    wait_ps(base + k, k * 260 + 10);
    en = 1'b0;
    wait_idle();
  endtask

  task automatic chk_reset();
    chk("rst_clk_out", clk_out, 0);
    chk("rst_period_start", period_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
  endtask

  task automatic load_cfg(input int m, input int n, input bit legal);
    int c;
    c = 0;
    while (!cfg_ready && c < 50) begin
      step();
      c++;
    end
    cfg_m     = 8'(m);
    cfg_n     = 8'(n);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    if (!legal) begin
      chk("rej_cfg_err", cfg_err, 1);
      chk("rej_cfg_ready", cfg_ready, 1);
      step();
      chk("rej_err_pulse", cfg_err, 0);
    end else begin
      chk("acc_cfg_err", cfg_err, 0);
      c = 0;
      while (!cfg_ready && c < 100) begin
        c++;
        step();
      end
      chk("ready_low_cycles", c, 9);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    int   cur_m, cur_n, base, prev, c;
    int   l87[10];
    vecs[0] = '{40, 5, 1'b1, 6};
    vecs[1] = '{9, 5, 1'b0, 3};
    vecs[2] = '{20, 0, 1'b0, 3};
    vecs[3] = '{3, 2, 1'b0, 3};
    vecs[4] = '{30, 3, 1'b1, 3};
    vecs[5] = '{4, 2, 1'b1, 5};
    vecs[6] = '{5, 2, 1'b1, 4};
    vecs[7] = '{255, 1, 1'b1, 2};
    vecs[8] = '{200, 7, 1'b1, 8};
    vecs[9] = '{250, 9, 1'b1, 10};
    l87 = '{8, 9, 9, 8, 9, 9, 8, 9, 9, 9};

    // Reset state
    step();
    step();
    chk_reset();
    rst = 1'b1;
    step();
    chk_reset();

    // 87/10: handshake latency, first-period latency, ten-period pattern
    load_cfg(87, 10, 1'b1);
    for (int i = 0; i < 10; i++) exp_q.push_back('{l87[i], 4});
    tot_len = 0;
    en   = 1'b1;
    base = ps_cnt;
    step();
    chk("first_ps_early", period_start, 0);
    step();
    chk("first_ps", period_start, 1);
    chk("first_clk_out", clk_out, 1);
    chk("busy_on", busy, 1);
    wait_ps(base + 10, 200);
    en = 1'b0;
    wait_idle();
    chk("total_87", tot_len, 87);
    cur_m = 87;
    cur_n = 10;

    // Table: legal configs run through the model, illegal keep the old one
    for (int v = 0; v < 10; v++) begin
      load_cfg(vecs[v].m, vecs[v].n, vecs[v].legal);
      if (vecs[v].legal) begin
        cur_m = vecs[v].m;
        cur_n = vecs[v].n;
      end
      push_model(cur_m, cur_n, vecs[v].nper);
      run_periods(vecs[v].nper);
    end

    // Reconfig while running 87/10 -> 30/3 lands on the boundary after period 2
    load_cfg(87, 10, 1'b1);
    exp_q.push_back('{8, 4});
    exp_q.push_back('{9, 4});
    for (int i = 0; i < 3; i++) exp_q.push_back('{10, 5});
    en   = 1'b1;
    base = ps_cnt;
    wait_ps(base + 1, 20);
    cfg_m     = 8'd30;
    cfg_n     = 8'd3;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("reconf_ready_low", cfg_ready, 0);
    prev = 1;
    c    = 0;
    while (ps_cnt < base + 3 && c < 60) begin
      prev = int'(cfg_ready);
      step();
      c++;
    end
    chk("reconf_ps_seen", ps_cnt, base + 3);
    chk("reconf_ready_pre_boundary", prev, 0);
    chk("reconf_ready_at_boundary", cfg_ready, 1);
    wait_ps(base + 5, 60);
    en = 1'b0;
    wait_idle();

    // en dropped in the high phase of a 9-cycle period
    load_cfg(87, 10, 1'b1);
    exp_q.push_back('{8, 4});
    exp_q.push_back('{9, 4});
    en   = 1'b1;
    base = ps_cnt;
    wait_ps(base + 2, 30);
    en = 1'b0;
    wait_idle();
    repeat (5) step();
    chk("stopped_clk_out", clk_out, 0);
    chk("stopped_ps", ps_cnt, base + 2);

    // Reset mid-period aborts at once
    load_cfg(40, 5, 1'b1);
    exp_q.push_back('{8, 4});
    en   = 1'b1;
    base = ps_cnt;
    wait_ps(base + 2, 30);
    step();
    step();
    rst = 1'b0;
    en  = 1'b0;
    #1;
    chk_reset();
    step();
    step();
    rst = 1'b1;
    step();
    chk("sb_after_reset", exp_q.size(), 0);

    // Enable after reset: only the default-config build produces output
    en   = 1'b1;
    base = ps_cnt;
`ifdef FRAC_DIV_DEFAULT_CFG_EN
    push_model(87, 10, 3);
    wait_ps(base + 3, 100);
    en = 1'b0;
    wait_idle();
`else
    repeat (30) step();
    chk("nocfg_ps", ps_cnt - base, 0);
    chk("nocfg_busy", busy, 0);
    chk("nocfg_clk_out", clk_out, 0);
    en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
